// File: rtl/rv_g_pkg.sv
// Shared definitions for the rv_g operand-fetch / regfile interface.
// Contents: register address width, operand-fetch FSM state encoding,
//           and the helper that derives the operand data width.
package rv_g_pkg;

    localparam int RF_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } operand_fetch_state_e;

    // Operand width must hold either an integer or a floating-point register.
    function automatic int calc_maxlen(input int xlen, input int flen);
        return (xlen > flen) ? xlen : flen;
    endfunction

endpackage

// File: rtl/rv_g_operand_fetch.sv
// Purpose : requests rd lock + rs1/rs2/rs3 reads from rv_g_regfile for one uop,
//           captures the operands on grant and presents uop + operands to execute.
// Latency : accept edge -> out_valid_o after 2 edges minimum (one REQ cycle);
//           one uop per 2 cycles with immediate grant.
// Backpressure: regfile holds us in REQ (addresses stable) until gnt; execute holds
//           us in OUT (outputs stable) until out_ready_i, which also gates in_ready_o.
// Ports   : clk_i/rst_i/flush_i; in_* uop + register addresses (valid/ready);
//           rf_* request/addresses out, grant + read data in; out_* uop/rd/operands
//           (valid/ready); stall_cnt_o saturating count of cycles waiting for gnt.
module rv_g_operand_fetch
    import rv_g_pkg::*;
#(
    parameter  int XLEN   = 64,
    parameter  int FLEN   = 32,
    parameter  int UOP_W  = 32,
    localparam int MAXLEN = calc_maxlen(XLEN, FLEN)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,

    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [UOP_W-1:0]     in_uop_i,
    input  logic [RF_ADDR_W-1:0] in_rd_addr_i,
    input  logic [RF_ADDR_W-1:0] in_rs1_addr_i,
    input  logic [RF_ADDR_W-1:0] in_rs2_addr_i,
    input  logic [RF_ADDR_W-1:0] in_rs3_addr_i,

    output logic                 rf_req_o,
    output logic [RF_ADDR_W-1:0] rf_rd_addr_o,
    output logic [RF_ADDR_W-1:0] rf_rs1_addr_o,
    output logic [RF_ADDR_W-1:0] rf_rs2_addr_o,
    output logic [RF_ADDR_W-1:0] rf_rs3_addr_o,
    input  logic                 rf_gnt_i,
    input  logic [MAXLEN-1:0]    rf_rs1_data_i,
    input  logic [MAXLEN-1:0]    rf_rs2_data_i,
    input  logic [MAXLEN-1:0]    rf_rs3_data_i,

    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [UOP_W-1:0]     out_uop_o,
    output logic [RF_ADDR_W-1:0] out_rd_addr_o,
    output logic [MAXLEN-1:0]    out_rs1_data_o,
    output logic [MAXLEN-1:0]    out_rs2_data_o,
    output logic [MAXLEN-1:0]    out_rs3_data_o,

    output logic [15:0]          stall_cnt_o
);

    operand_fetch_state_e r_state;

    logic [UOP_W-1:0]     r_uop;
    logic [RF_ADDR_W-1:0] r_rd_addr;
    logic [RF_ADDR_W-1:0] r_rs1_addr;
    logic [RF_ADDR_W-1:0] r_rs2_addr;
    logic [RF_ADDR_W-1:0] r_rs3_addr;

    logic [UOP_W-1:0]     r_out_uop;
    logic [RF_ADDR_W-1:0] r_out_rd_addr;
    logic [MAXLEN-1:0]    r_out_rs1_data;
    logic [MAXLEN-1:0]    r_out_rs2_data;
    logic [MAXLEN-1:0]    r_out_rs3_data;
    logic [15:0]          r_stall_cnt;

    logic w_req;
    logic w_gnt;
    logic w_out_hs;
    logic w_in_ready;
    logic w_accept;

    // Request is masked by flush/reset combinationally so the regfile can never
    // grant (and lock rd) in a cycle whose result we are about to throw away.
    assign w_req      = (r_state == REQ) & ~flush_i & ~rst_i;
    assign w_gnt      = w_req & rf_gnt_i;
    assign w_out_hs   = (r_state == OUT) & out_ready_i;
    // In OUT a new uop may only enter on the same edge the current one leaves.
    assign w_in_ready = ~rst_i & ~flush_i & ((r_state == IDLE) | w_out_hs);
    assign w_accept   = in_valid_i & w_in_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_uop          <= '0;
            r_rd_addr      <= '0;
            r_rs1_addr     <= '0;
            r_rs2_addr     <= '0;
            r_rs3_addr     <= '0;
            r_out_uop      <= '0;
            r_out_rd_addr  <= '0;
            r_out_rs1_data <= '0;
            r_out_rs2_data <= '0;
            r_out_rs3_data <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_req && !rf_gnt_i && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end

            // w_accept is already false under flush, so this latch is safe here.
            if (w_accept) begin
                r_uop      <= in_uop_i;
                r_rd_addr  <= in_rd_addr_i;
                r_rs1_addr <= in_rs1_addr_i;
                r_rs2_addr <= in_rs2_addr_i;
                r_rs3_addr <= in_rs3_addr_i;
            end

            if (w_gnt) begin
                r_out_uop      <= r_uop;
                r_out_rd_addr  <= r_rd_addr;
                r_out_rs1_data <= rf_rs1_data_i;
                r_out_rs2_data <= rf_rs2_data_i;
                r_out_rs3_data <= rf_rs3_data_i;
            end

            if (flush_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (w_accept) r_state <= REQ;
                    REQ:  if (w_gnt)    r_state <= OUT;
                    OUT:  if (w_out_hs) r_state <= w_accept ? REQ : IDLE;
                    default:            r_state <= IDLE;
                endcase
            end
        end
    end

    assign in_ready_o     = w_in_ready;
    assign rf_req_o       = w_req;
    assign rf_rd_addr_o   = r_rd_addr;
    assign rf_rs1_addr_o  = r_rs1_addr;
    assign rf_rs2_addr_o  = r_rs2_addr;
    assign rf_rs3_addr_o  = r_rs3_addr;
    assign out_valid_o    = (r_state == OUT) & ~rst_i;
    assign out_uop_o      = r_out_uop;
    assign out_rd_addr_o  = r_out_rd_addr;
    assign out_rs1_data_o = r_out_rs1_data;
    assign out_rs2_data_o = r_out_rs2_data;
    assign out_rs3_data_o = r_out_rs3_data;
    assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_rv_g_operand_fetch.sv
// Directed bench for rv_g_operand_fetch: a tiny regfile stand-in returns
// {4'hD, epoch, 50'b0, addr} per source port and counts grants seen.
// Expected values are hand-computed constants.
module tb_rv_g_operand_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_uop_i = '0;
    logic [5:0]  in_rd_addr_i = '0;
    logic [5:0]  in_rs1_addr_i = '0;
    logic [5:0]  in_rs2_addr_i = '0;
    logic [5:0]  in_rs3_addr_i = '0;
    logic        rf_req_o;
    logic [5:0]  rf_rd_addr_o, rf_rs1_addr_o, rf_rs2_addr_o, rf_rs3_addr_o;
    logic        rf_gnt_i = 1'b0;
    logic [63:0] rf_rs1_data_i, rf_rs2_data_i, rf_rs3_data_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_uop_o;
    logic [5:0]  out_rd_addr_o;
    logic [63:0] out_rs1_data_o, out_rs2_data_o, out_rs3_data_o;
    logic [15:0] stall_cnt_o;

    logic [3:0]  epoch = 4'h0;
    int          gnt_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_i = ~clk_i;

    rv_g_operand_fetch #(.XLEN(64), .FLEN(32), .UOP_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_uop_i(in_uop_i),
        .in_rd_addr_i(in_rd_addr_i), .in_rs1_addr_i(in_rs1_addr_i),
        .in_rs2_addr_i(in_rs2_addr_i), .in_rs3_addr_i(in_rs3_addr_i),
        .rf_req_o(rf_req_o), .rf_rd_addr_o(rf_rd_addr_o),
        .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
        .rf_rs3_addr_o(rf_rs3_addr_o), .rf_gnt_i(rf_gnt_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .rf_rs3_data_i(rf_rs3_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_uop_o(out_uop_o),
        .out_rd_addr_o(out_rd_addr_o), .out_rs1_data_o(out_rs1_data_o),
        .out_rs2_data_o(out_rs2_data_o), .out_rs3_data_o(out_rs3_data_o),
        .stall_cnt_o(stall_cnt_o)
    );

    // Regfile stand-in: read data tagged with the current epoch and address.
    assign rf_rs1_data_i = {4'hD, epoch, 50'b0, rf_rs1_addr_o};
    assign rf_rs2_data_i = {4'hD, epoch, 50'b0, rf_rs2_addr_o};
    assign rf_rs3_data_i = {4'hD, epoch, 50'b0, rf_rs3_addr_o};

    always @(posedge clk_i) begin
        if (rf_req_o && rf_gnt_i) gnt_cnt <= gnt_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_uop(input logic [31:0] uop, input logic [5:0] rd,
                             input logic [5:0] rs1, input logic [5:0] rs2,
                             input logic [5:0] rs3);
        in_valid_i    = 1'b1;
        in_uop_i      = uop;
        in_rd_addr_i  = rd;
        in_rs1_addr_i = rs1;
        in_rs2_addr_i = rs2;
        in_rs3_addr_i = rs3;
    endtask

    int bad;
    int gnt_before;

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        check("rst_in_ready", in_ready_o, 0);
        check("rst_rf_req", rf_req_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_rs1", out_rs1_data_o, 0);
        check("rst_rf_rs1_addr", rf_rs1_addr_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        rst_i = 1'b0;
        #1;
        check("idle_in_ready", in_ready_o, 1);

        // ---------------- basic op, immediate grant ----------------
        rf_gnt_i = 1'b1;
        drive_uop(32'hCAFE_0001, 6'd5, 6'd1, 6'd2, 6'd0);
        step();                         // accept edge
        in_valid_i = 1'b0;
        check("t1_req", rf_req_o, 1);
        check("t1_rd_addr", rf_rd_addr_o, 5);
        check("t1_rs2_addr", rf_rs2_addr_o, 2);
        check("t1_rs3_addr_x0", rf_rs3_addr_o, 0);
        check("t1_no_valid_yet", out_valid_o, 0);
        check("t1_in_ready_req", in_ready_o, 0);
        step();                         // grant edge
        check("t1_valid", out_valid_o, 1);
        check("t1_uop", out_uop_o, 64'hCAFE_0001);
        check("t1_out_rd", out_rd_addr_o, 5);
        check("t1_rs1", out_rs1_data_o, 64'hD000_0000_0000_0001);
        check("t1_rs2", out_rs2_data_o, 64'hD000_0000_0000_0002);
        check("t1_rs3", out_rs3_data_o, 64'hD000_0000_0000_0000);
        check("t1_stall", stall_cnt_o, 0);
        check("t1_gnts", gnt_cnt, 1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("t1_drained", out_valid_o, 0);

        // ---------------- 7 stall cycles, then grant ----------------
        rf_gnt_i = 1'b0;
        drive_uop(32'hCAFE_0002, 6'd7, 6'd33, 6'd40, 6'd63);
        step();
        in_valid_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (rf_req_o !== 1'b1 || rf_rs1_addr_o !== 6'd33 || rf_rs2_addr_o !== 6'd40 ||
                rf_rs3_addr_o !== 6'd63 || rf_rd_addr_o !== 6'd7) bad++;
            step();
        end
        check("t2_req_addr_stable", bad, 0);
        check("t2_still_waiting", out_valid_o, 0);
        epoch = 4'h1;
        rf_gnt_i = 1'b1;
        #1;
        check("t2_stall7", stall_cnt_o, 7);
        step();
        rf_gnt_i = 1'b0;
        check("t2_valid", out_valid_o, 1);
        check("t2_rs1", out_rs1_data_o, 64'hD100_0000_0000_0021);
        check("t2_rs2", out_rs2_data_o, 64'hD100_0000_0000_0028);
        check("t2_rs3", out_rs3_data_o, 64'hD100_0000_0000_003F);
        check("t2_stall_hold", stall_cnt_o, 7);

        // ---------------- backpressure in OUT, then handoff + accept ----------------
        epoch = 4'h2;
        drive_uop(32'hCAFE_0003, 6'd9, 6'd3, 6'd4, 6'd5);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 ||
                out_rs1_data_o !== 64'hD100_0000_0000_0021 ||
                out_uop_o !== 32'hCAFE_0002 || out_rd_addr_o !== 6'd7) bad++;
            step();
        end
        check("t3_out_stable", bad, 0);
        out_ready_i = 1'b1;
        #1;
        check("t3_in_ready_follows", in_ready_o, 1);
        step();                         // handoff + accept on one edge
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        check("t3_valid_dropped", out_valid_o, 0);
        check("t3_req", rf_req_o, 1);
        check("t3_rs1_addr", rf_rs1_addr_o, 3);
        check("t3_rd_addr", rf_rd_addr_o, 9);

        // ---------------- flush in REQ while regfile would grant ----------------
        gnt_before = gnt_cnt;
        rf_gnt_i = 1'b1;
        flush_i = 1'b1;
        in_valid_i = 1'b1;              // must not be accepted during flush
        #1;
        check("t4_req_masked", rf_req_o, 0);
        check("t4_in_ready_flush", in_ready_o, 0);
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        rf_gnt_i = 1'b0;
        #1;
        check("t4_no_lock", gnt_cnt, gnt_before);
        check("t4_idle_req", rf_req_o, 0);
        check("t4_idle_valid", out_valid_o, 0);
        check("t4_idle_ready", in_ready_o, 1);
        check("t4_stall", stall_cnt_o, 7);

        // ---------------- reset pulse mid-OUT ----------------
        rf_gnt_i = 1'b1;
        drive_uop(32'hCAFE_0004, 6'd10, 6'd6, 6'd7, 6'd8);
        step();
        in_valid_i = 1'b0;
        step();
        check("t5_in_out", out_valid_o, 1);
        rst_i = 1'b1;
        #1;
        check("t5_rst_valid", out_valid_o, 0);
        check("t5_rst_ready", in_ready_o, 0);
        check("t5_rst_req", rf_req_o, 0);
        step();
        check("t5_rst_rs1", out_rs1_data_o, 0);
        check("t5_rst_uop", out_uop_o, 0);
        check("t5_rst_rd", out_rd_addr_o, 0);
        check("t5_rst_addr", rf_rs1_addr_o, 0);
        check("t5_rst_stall", stall_cnt_o, 0);
        rst_i = 1'b0;
        #1;
        check("t5_ready_after", in_ready_o, 1);

        // ---------------- counter saturation ----------------
        rf_gnt_i = 1'b0;
        drive_uop(32'hCAFE_0005, 6'd11, 6'd12, 6'd13, 6'd14);
        step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 70000; i++) step();
        check("t6_sat", stall_cnt_o, 16'hFFFF);
        check("t6_req_held", rf_req_o, 1);
        rf_gnt_i = 1'b1;
        step();
        rf_gnt_i = 1'b0;
        check("t6_valid", out_valid_o, 1);
        check("t6_sat_hold", stall_cnt_o, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
